// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave in front of a word-addressed register-array memory.
// Latency: AR handshake at edge N -> rvalid after edge N+R_DELAY; AW+W complete at edge N -> bvalid after edge N+1.
// Backpressure: rvalid/bvalid are held until rready/bready; arready drops while a read is
//   outstanding; awready/wready drop while that channel is held or a B response is pending.
//
// Ports:
//   aclk, aresetn          clock (rising edge) and asynchronous active-low reset
//   ar*/r*                 read address / read data channels; rid echoes arid, rlast = rvalid
//   aw*/w*/b*              write address / data / response channels; bid echoes awid
//   rresp/bresp            always OKAY
module axi_sram_slave #(
   parameter int DEPTH_LOG2 = 12,
   parameter int R_DELAY    = 1,
   parameter int ID_W       = 4
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic            arvalid,
   output logic            arready,
   output logic [ID_W-1:0] rid,
   output logic [31:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready,
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic            awvalid,
   output logic            awready,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   input  logic            wvalid,
   output logic            wready,
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready
);

   localparam int         DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [3:0] DELAY_INIT = 4'(R_DELAY);
   localparam bit         ZERO_DELAY = (R_DELAY == 0);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } rstate_t;

   logic [31:0]           r_mem [DEPTH];

   // read path
   rstate_t               r_rstate;
   rstate_t               w_rstate_nxt;
   logic [3:0]            r_cnt;
   logic [DEPTH_LOG2-1:0] r_ridx;
   logic [DEPTH_LOG2-1:0] w_ar_idx;
   logic [DEPTH_LOG2-1:0] w_rd_idx;
   logic [ID_W-1:0]       r_rid;
   logic [31:0]           r_rdata;
   logic                  w_ar_hs;
   logic                  w_rd_sample;

   // write path
   logic                  r_aw_held;
   logic                  r_w_held;
   logic                  r_bvalid;
   logic [ID_W-1:0]       r_awid;
   logic [ID_W-1:0]       r_bid;
   logic [DEPTH_LOG2-1:0] r_widx;
   logic [DEPTH_LOG2-1:0] w_aw_idx;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_commit;

   // Address bits outside the word index are ignored, so the array wraps.
   logic                  w_unused_addr_bits;
   assign w_unused_addr_bits = ^{araddr[31:DEPTH_LOG2+2], araddr[1:0],
                                 awaddr[31:DEPTH_LOG2+2], awaddr[1:0]};

   assign w_ar_idx = araddr[DEPTH_LOG2+1:2];
   assign w_aw_idx = awaddr[DEPTH_LOG2+1:2];
   assign w_ar_hs  = arvalid & arready;
   // With zero delay the word is sampled on the AR handshake edge itself.
   assign w_rd_idx = (r_rstate == R_IDLE) ? w_ar_idx : r_ridx;

   // ---------------- read FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_rstate <= R_IDLE;
      else          r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      arready      = 1'b0;
      rvalid       = 1'b0;
      w_rd_sample  = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               if (ZERO_DELAY) begin
                  w_rstate_nxt = R_RESP;
                  w_rd_sample  = 1'b1;
               end else begin
                  w_rstate_nxt = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (r_cnt == 4'd1) begin
               w_rstate_nxt = R_RESP;
               w_rd_sample  = 1'b1;
            end
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cnt   <= 4'd0;
         r_ridx  <= '0;
         r_rid   <= '0;
         r_rdata <= 32'd0;
      end else begin
         if (w_ar_hs) begin
            r_cnt  <= DELAY_INIT;
            r_ridx <= w_ar_idx;
            r_rid  <= arid;
         end else if (r_rstate == R_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         // Nonblocking sample: a write committing on this same edge is not yet visible.
         if (w_rd_sample) r_rdata <= r_mem[w_rd_idx];
      end
   end

   assign rid   = r_rid;
   assign rdata = r_rdata;
   assign rresp = 2'b00;
   assign rlast = rvalid;

   // ---------------- write path ----------------
   assign awready  = ~r_aw_held & ~r_bvalid;
   assign wready   = ~r_w_held  & ~r_bvalid;
   assign w_aw_hs  = awvalid & awready;
   assign w_w_hs   = wvalid & wready;
   assign w_commit = r_aw_held & r_w_held;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_awid    <= '0;
         r_bid     <= '0;
         r_widx    <= '0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'd0;
      end else begin
         // Both held flags are clear while bvalid is high, so commit and
         // B handshake never coincide.
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bid     <= r_awid;
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_awid    <= awid;
               r_widx    <= w_aw_idx;
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_wdata  <= wdata;
               r_wstrb  <= wstrb;
            end
            if (r_bvalid && bready) r_bvalid <= 1'b0;
         end
      end
   end

   // Memory contents survive reset; only the byte lanes enabled by wstrb change.
   always_ff @(posedge aclk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (r_wstrb[i]) r_mem[r_widx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end

   assign bid    = r_bid;
   assign bresp  = 2'b00;
   assign bvalid = r_bvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

   localparam int ID_W = 4;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;
   logic aresetn;

   // DUT with R_DELAY = 1
   logic [ID_W-1:0] arid, rid, awid, bid;
   logic [31:0]     araddr, rdata, awaddr, wdata;
   logic [1:0]      rresp, bresp;
   logic [3:0]      wstrb;
   logic arvalid, arready, rlast, rvalid, rready;
   logic awvalid, awready, wvalid, wready, bvalid, bready;

   // DUT with R_DELAY = 3
   logic [ID_W-1:0] d3_arid, d3_rid, d3_awid, d3_bid;
   logic [31:0]     d3_araddr, d3_rdata, d3_awaddr, d3_wdata;
   logic [1:0]      d3_rresp, d3_bresp;
   logic [3:0]      d3_wstrb;
   logic d3_arvalid, d3_arready, d3_rlast, d3_rvalid, d3_rready;
   logic d3_awvalid, d3_awready, d3_wvalid, d3_wready, d3_bvalid, d3_bready;

   axi_sram_slave #(.DEPTH_LOG2(12), .R_DELAY(1), .ID_W(ID_W)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   axi_sram_slave #(.DEPTH_LOG2(12), .R_DELAY(3), .ID_W(ID_W)) u_dut3 (
      .aclk(aclk), .aresetn(aresetn),
      .arid(d3_arid), .araddr(d3_araddr), .arvalid(d3_arvalid), .arready(d3_arready),
      .rid(d3_rid), .rdata(d3_rdata), .rresp(d3_rresp), .rlast(d3_rlast), .rvalid(d3_rvalid),
      .rready(d3_rready),
      .awid(d3_awid), .awaddr(d3_awaddr), .awvalid(d3_awvalid), .awready(d3_awready),
      .wdata(d3_wdata), .wstrb(d3_wstrb), .wvalid(d3_wvalid), .wready(d3_wready),
      .bid(d3_bid), .bresp(d3_bresp), .bvalid(d3_bvalid), .bready(d3_bready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference memory: word index -> contents
   logic [31:0] mdl [int];

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & 32'h0000_0FFF);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W; 0: together.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [ID_W-1:0] id, input int gap, input int hold_b);
      bit aw_done, w_done, aw_hs, w_hs;
      int cyc, aw_at, w_at;
      aw_done = 0; w_done = 0; cyc = 0;
      aw_at = (gap > 0) ? gap : 0;
      w_at  = (gap < 0) ? -gap : 0;
      awaddr = a; awid = id; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid = !aw_done && (cyc >= aw_at);
         wvalid  = !w_done && (cyc >= w_at);
         if (aw_done) chk1("aw_held_awready", awready, 1'b0);
         if (w_done)  chk1("w_held_wready", wready, 1'b0);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         aw_done |= aw_hs;
         w_done  |= w_hs;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk1("write_accepted", aw_done && w_done, 1'b1);
      chk1("b_not_early", bvalid, 1'b0);
      tick();
      chk1("b_after_commit", bvalid, 1'b1);
      chk32("bid", 32'(bid), 32'(id));
      chk32("bresp", 32'(bresp), 32'd0);
      for (int i = 0; i < hold_b; i++) begin
         chk1("b_hold_awready", awready, 1'b0);
         chk1("b_hold_wready", wready, 1'b0);
         chk1("b_hold_bvalid", bvalid, 1'b1);
         chk32("b_hold_bid", 32'(bid), 32'(id));
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk1("b_cleared", bvalid, 1'b0);
      mdl[widx(a)] = merge(mdl.exists(widx(a)) ? mdl[widx(a)] : 32'd0, d, s);
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [ID_W-1:0] id, input int exp_lat,
                           input int hold_r, output logic [31:0] d);
      int k;
      araddr = a; arid = id; arvalid = 1'b1;
      k = 0;
      while (!arready && k < 20) begin tick(); k++; end
      tick();
      arvalid = 1'b0;
      k = 0;
      while (!rvalid && k < 20) begin tick(); k++; end
      chk32("r_latency", 32'(k), 32'(exp_lat));
      d = rdata;
      for (int i = 0; i < hold_r; i++) begin
         chk1("r_hold_rvalid", rvalid, 1'b1);
         chk1("r_hold_arready", arready, 1'b0);
         chk32("r_hold_rdata", rdata, d);
         tick();
      end
      chk32("rid", 32'(rid), 32'(id));
      chk1("rlast", rlast, 1'b1);
      chk32("rresp", 32'(rresp), 32'd0);
      chk1("arready_in_resp", arready, 1'b0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk1("r_cleared", rvalid, 1'b0);
      chk1("arready_back", arready, 1'b1);
   endtask

   initial begin
      logic [31:0] rd, a, d, old;
      logic [3:0]  s;
      logic [ID_W-1:0] id;
      int k;

      aresetn = 1'b0;
      arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awid = '0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      d3_arid = '0; d3_araddr = '0; d3_arvalid = 1'b0; d3_rready = 1'b0;
      d3_awid = '0; d3_awaddr = '0; d3_awvalid = 1'b0; d3_wdata = '0; d3_wstrb = '0;
      d3_wvalid = 1'b0; d3_bready = 1'b0;
      repeat (3) tick();

      // ---- reset state ----
      chk1("rst_rvalid", rvalid, 1'b0);
      chk1("rst_bvalid", bvalid, 1'b0);
      chk32("rst_rid", 32'(rid), 32'd0);
      chk32("rst_bid", 32'(bid), 32'd0);
      chk32("rst_rdata", rdata, 32'd0);
      aresetn = 1'b1;
      tick();
      chk1("rst_arready", arready, 1'b1);
      chk1("rst_awready", awready, 1'b1);
      chk1("rst_wready", wready, 1'b1);

      // ---- AW+W together, then read back ----
      axi_write(32'h100, 32'hDEADBEEF, 4'hF, 4'h1, 0, 0);
      axi_read(32'h100, 4'h1, 1, 0, rd);
      chk32("rd_0x100", rd, 32'hDEADBEEF);

      // ---- W three cycles before AW, partial strobe ----
      axi_write(32'h104, 32'hFFFFFFFF, 4'hF, 4'h2, 0, 0);
      axi_write(32'h104, 32'h11223344, 4'b0101, 4'h3, 3, 0);
      axi_read(32'h104, 4'h4, 1, 0, rd);
      chk32("rd_strb_merge", rd, 32'hFF22FF44);

      // ---- AW leading W, B stalled 4 cycles, next write right after ----
      axi_write(32'h10C, 32'h0A0B0C0D, 4'hF, 4'h5, -2, 4);
      chk1("ready_after_b_aw", awready, 1'b1);
      chk1("ready_after_b_w", wready, 1'b1);
      axi_write(32'h110, 32'h55667788, 4'hF, 4'h6, 0, 0);
      axi_read(32'h10C, 4'h7, 1, 2, rd);
      chk32("rd_0x10c", rd, mdl[widx(32'h10C)]);

      // ---- alias: upper address bits ignored ----
      axi_read(32'h4100, 4'h8, 1, 0, rd);
      chk32("rd_alias", rd, 32'hDEADBEEF);

      // ---- read sampling on the commit edge sees old data ----
      old = mdl[widx(32'h100)];
      araddr = 32'h100; arid = 4'h2; arvalid = 1'b1;
      awaddr = 32'h100; awid = 4'h3; awvalid = 1'b1;
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
      chk1("rw_arready", arready, 1'b1);
      chk1("rw_awready", awready, 1'b1);
      tick();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      tick();
      chk1("rw_rvalid", rvalid, 1'b1);
      chk1("rw_bvalid", bvalid, 1'b1);
      chk32("rw_read_old", rdata, old);
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      mdl[widx(32'h100)] = 32'hCAFEF00D;
      axi_read(32'h100, 4'h2, 1, 0, rd);
      chk32("rw_read_new", rd, 32'hCAFEF00D);

      // ---- R_DELAY = 3 instance: latency and rready stall ----
      d3_awaddr = 32'h40; d3_awid = 4'h2; d3_wdata = 32'h5A5AA5A5; d3_wstrb = 4'hF;
      d3_awvalid = 1'b1; d3_wvalid = 1'b1;
      chk1("d3_awready", d3_awready, 1'b1);
      chk1("d3_wready", d3_wready, 1'b1);
      tick();
      d3_awvalid = 1'b0; d3_wvalid = 1'b0;
      tick();
      chk1("d3_bvalid", d3_bvalid, 1'b1);
      chk32("d3_bid", 32'(d3_bid), 32'h2);
      chk32("d3_bresp", 32'(d3_bresp), 32'd0);
      d3_bready = 1'b1;
      tick();
      d3_bready = 1'b0;
      d3_araddr = 32'h40; d3_arid = 4'h9; d3_arvalid = 1'b1;
      chk1("d3_arready", d3_arready, 1'b1);
      tick();
      d3_arvalid = 1'b0;
      k = 0;
      while (!d3_rvalid && k < 20) begin tick(); k++; end
      chk32("d3_r_latency", 32'(k), 32'd3);
      for (int i = 0; i < 5; i++) begin
         chk1("d3_hold_rvalid", d3_rvalid, 1'b1);
         chk1("d3_hold_arready", d3_arready, 1'b0);
         chk32("d3_hold_rdata", d3_rdata, 32'h5A5AA5A5);
         chk32("d3_hold_rid", 32'(d3_rid), 32'h9);
         chk1("d3_hold_rlast", d3_rlast, 1'b1);
         chk32("d3_rresp", 32'(d3_rresp), 32'd0);
         tick();
      end
      d3_rready = 1'b1;
      tick();
      d3_rready = 1'b0;
      chk1("d3_r_cleared", d3_rvalid, 1'b0);

      // ---- randomized traffic against the reference memory ----
      for (int i = 0; i < 8; i++)
         axi_write(32'h300 + 32'(4 * i), $urandom, 4'hF, 4'(i), 0, 0);
      for (int n = 0; n < 40; n++) begin
         a  = 32'h300 + 32'(4 * $urandom_range(0, 7)) + (32'($urandom_range(0, 3)) << 14);
         id = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, id, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
         end else begin
            axi_read(a, id, 1, int'($urandom_range(0, 2)), rd);
            chk32("rand_read", rd, mdl[widx(a)]);
         end
      end

      // ---- reset while in R_RESP with AW held ----
      axi_write(32'h108, 32'h13579BDF, 4'hF, 4'h1, 0, 0);
      araddr = 32'h104; arid = 4'h3; arvalid = 1'b1;
      awaddr = 32'h108; awid = 4'h4; awvalid = 1'b1;
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
      tick();
      chk1("pre_rst_rvalid", rvalid, 1'b1);
      chk1("pre_rst_aw_held", awready, 1'b0);
      aresetn = 1'b0;
      #1;
      chk1("mid_rst_rvalid", rvalid, 1'b0);
      chk1("mid_rst_bvalid", bvalid, 1'b0);
      chk1("mid_rst_aw_dropped", awready, 1'b1);
      #2;
      aresetn = 1'b1;
      tick();
      // A lone W must not pair with the discarded AW.
      wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      tick();
      tick();
      chk1("post_rst_no_commit", bvalid, 1'b0);
      aresetn = 1'b0;
      #2;
      aresetn = 1'b1;
      tick();
      axi_read(32'h108, 4'h5, 1, 0, rd);
      chk32("post_rst_mem", rd, 32'h13579BDF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
